// File: rtl/vld_stream_fifo.sv
// Elastic first-word-fall-through buffer behind the valid-tagged SRL delay line.
// It turns the push-only stream into valid/ready and reports throttle, overflow and high-water status.
module vld_stream_fifo #(
  parameter int DATA_WIDTH   = 18,
  parameter int DEPTH        = 64,
  parameter int AFULL_MARGIN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din_vld,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    din_afull,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  hwm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [CW-1:0]         r_hwm;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_drop;
  logic [CW-1:0]         w_count_nxt;

  // Handshake: the input side has no backpressure, a word is taken whenever din_vld is high
  // and there is room (or a read frees a slot the same cycle); the output side transfers a
  // word on every cycle where m_valid & m_ready, and m_valid never depends on m_ready.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_rd    = ~w_empty & m_ready;
  assign w_wr    = din_vld & (~w_full | w_rd);
  assign w_drop  = din_vld & w_full & ~w_rd;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)
      w_count_nxt = r_count + CW'(1);
    else if (w_rd && !w_wr)
      w_count_nxt = r_count - CW'(1);
  end

  // Storage carries no reset; stale contents are masked by m_valid.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hwm      <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_count_nxt > r_hwm)
        r_hwm <= w_count_nxt;
    end
  end

  assign m_valid   = ~w_empty;
  assign m_data    = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign hwm       = r_hwm;
  // Taken from the registered count, so it lags a count change by one cycle.
  assign din_afull = (r_count >= AFULL_TH);

endmodule
